// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM stage, the debug read-out unit and the data memory.
// slave = arbiter side, master = environment side (pipeline, debug unit, memory).
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) ();

    logic              pipe_we;
    logic              pipe_re;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic [DATA_W-1:0] pipe_rdata;
    logic              pipe_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  pipe_we, pipe_re, pipe_addr, pipe_wdata,
        output pipe_rdata, pipe_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output pipe_we, pipe_re, pipe_addr, pipe_wdata,
        input  pipe_rdata, pipe_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage (priority) and the debug unit.
// Define DMEM_ARB_STARVE_EN to build the wait counter that forces a grant after STARVE_LIMIT cycles.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("dmem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_e            state_q, state_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic pipe_busy;
    logic accept;
    logic starved;

    assign pipe_busy = bus.pipe_we | bus.pipe_re;
    // A request still held during its own ack cycle must not start a second transaction.
    assign accept    = bus.dbg_req & ~dbg_ack_q;

`ifdef DMEM_ARB_STARVE_EN
    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign starved = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && accept && pipe_busy) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT && pipe_busy && !starved) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        dbg_ack_d   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_we_d    = bus.dbg_we;
                    req_addr_d  = bus.dbg_addr;
                    req_wdata_d = bus.dbg_wdata;
                    state_d     = pipe_busy ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (!pipe_busy || starved) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                dbg_rdata_d = bus.mem_rdata;
                dbg_ack_d   = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // NOTE: the latched request payload is only consumed after a fresh acceptance, so it carries no reset.
    always_ff @(posedge clk) begin
        req_we_q    <= req_we_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
    end

    // Memory port mux; reset gates the write enable so no store lands while the block is being reset.
    always_comb begin
        bus.mem_addr  = bus.pipe_addr;
        bus.mem_wdata = bus.pipe_wdata;
        bus.mem_we    = bus.pipe_we & ~reset;
        if (state_q == S_ACCESS) begin
            bus.mem_addr  = req_addr_q;
            bus.mem_wdata = req_wdata_q;
            bus.mem_we    = req_we_q & ~reset;
        end
    end

    assign bus.pipe_rdata = bus.mem_rdata;
    assign bus.pipe_stall = (state_q == S_ACCESS);
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural 16 x 32 sync-read memory.
// Follows DMEM_ARB_STARVE_EN: forced-grant scenario when defined, unbounded-wait scenario otherwise.
module tb_dmem_port_arbiter;

    localparam int ADDR_W       = 4;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

`ifdef DMEM_ARB_STARVE_EN
    localparam int BUSY_LAST = 7;
    localparam int STALL_C   = 5;
    localparam int ACK_C     = 7;
`else
    localparam int BUSY_LAST = 19;
    localparam int STALL_C   = 21;
    localparam int ACK_C     = 23;
`endif

    logic clk;
    logic reset;
    int unsigned checks;
    int unsigned failures;

    logic [DATA_W-1:0] mem [16];

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.pipe_we    = 1'b0;
        bus.pipe_re    = 1'b0;
        bus.pipe_addr  = '0;
        bus.pipe_wdata = '0;
        bus.dbg_req    = 1'b0;
        bus.dbg_we     = 1'b0;
        bus.dbg_addr   = '0;
        bus.dbg_wdata  = '0;
    endtask

    task automatic rand_inputs();
        bus.pipe_we    = 1'($urandom);
        bus.pipe_re    = 1'($urandom);
        bus.pipe_addr  = 4'($urandom);
        bus.pipe_wdata = $urandom;
        bus.dbg_req    = 1'($urandom);
        bus.dbg_we     = 1'($urandom);
        bus.dbg_addr   = 4'($urandom);
        bus.dbg_wdata  = $urandom;
    endtask

    task automatic pipe_store(input logic [3:0] addr, input logic [31:0] data);
        cyc();
        idle_inputs();
        bus.pipe_we    = 1'b1;
        bus.pipe_addr  = addr;
        bus.pipe_wdata = data;
        smp();
        check("store_we", 32'(bus.mem_we), 32'd1);
        check("store_addr", 32'(bus.mem_addr), 32'(addr));
        check("store_wdata", bus.mem_wdata, data);
    endtask

    initial begin
        logic [3:0] exp_addr;
        checks   = 0;
        failures = 0;

        // Reset with random inputs.
        reset = 1'b1;
        rand_inputs();
        for (int i = 0; i < 2; i++) begin
            cyc();
            rand_inputs();
            exp_addr = bus.pipe_addr;
            smp();
            check("rst_ack", 32'(bus.dbg_ack), 32'd0);
            check("rst_rdata", bus.dbg_rdata, 32'd0);
            check("rst_stall", 32'(bus.pipe_stall), 32'd0);
            check("rst_mem_we", 32'(bus.mem_we), 32'd0);
            check("rst_mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        end
        cyc();
        reset = 1'b0;
        idle_inputs();
        smp();
        check("post_rst_stall", 32'(bus.pipe_stall), 32'd0);

        // Idle-pipe debug read of a pipeline store.
        pipe_store(4'd5, 32'hDEAD_BEEF);
        cyc();
        idle_inputs();
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 4'd5;
        smp();
        check("rd_c0_stall", 32'(bus.pipe_stall), 32'd0);
        cyc();
        smp();
        check("rd_c1_stall", 32'(bus.pipe_stall), 32'd1);
        check("rd_c1_addr", 32'(bus.mem_addr), 32'd5);
        check("rd_c1_we", 32'(bus.mem_we), 32'd0);
        check("rd_c1_ack", 32'(bus.dbg_ack), 32'd0);
        cyc();
        smp();
        check("rd_c2_stall", 32'(bus.pipe_stall), 32'd0);
        check("rd_c2_ack", 32'(bus.dbg_ack), 32'd0);
        cyc();
        smp();
        check("rd_c3_ack", 32'(bus.dbg_ack), 32'd1);
        check("rd_c3_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
        check("rd_c3_stall", 32'(bus.pipe_stall), 32'd0);
        cyc();
        bus.dbg_req = 1'b0;
        smp();
        check("rd_c4_ack", 32'(bus.dbg_ack), 32'd0);
        check("rd_c4_no_reaccept", 32'(bus.pipe_stall), 32'd0);

        // Debug write, pipeline load held across ACCESS and reissued in RESP.
        cyc();
        idle_inputs();
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 4'd3;
        bus.dbg_wdata = 32'h1234_5678;
        smp();
        cyc();
        bus.pipe_re   = 1'b1;
        bus.pipe_addr = 4'd5;
        smp();
        check("wr_c1_stall", 32'(bus.pipe_stall), 32'd1);
        check("wr_c1_we", 32'(bus.mem_we), 32'd1);
        check("wr_c1_addr", 32'(bus.mem_addr), 32'd3);
        check("wr_c1_wdata", bus.mem_wdata, 32'h1234_5678);
        cyc();
        smp();
        check("wr_c2_addr", 32'(bus.mem_addr), 32'd5);
        check("wr_c2_ack", 32'(bus.dbg_ack), 32'd0);
        cyc();
        bus.dbg_req   = 1'b0;
        bus.pipe_addr = 4'd3;
        smp();
        check("wr_c3_ack", 32'(bus.dbg_ack), 32'd1);
        check("resp_load_rdata", bus.pipe_rdata, 32'hDEAD_BEEF);
        cyc();
        idle_inputs();
        smp();
        check("wr_then_load", bus.pipe_rdata, 32'h1234_5678);
        check("wr_c4_ack", 32'(bus.dbg_ack), 32'd0);

        // Busy pipeline: forced grant (guard on) or grant on first idle slot (guard off).
        for (int c = 0; c <= ACK_C + 1; c++) begin
            cyc();
            idle_inputs();
            if (c <= BUSY_LAST) begin
                bus.pipe_we    = 1'b1;
                bus.pipe_addr  = 4'd9;
                bus.pipe_wdata = 32'hA5A5_A5A5;
            end
            bus.dbg_req  = (c < ACK_C);
            bus.dbg_addr = 4'd5;
            smp();
            check($sformatf("busy_c%0d_stall", c), 32'(bus.pipe_stall), 32'(c == STALL_C));
            check($sformatf("busy_c%0d_ack", c), 32'(bus.dbg_ack), 32'(c == ACK_C));
            check($sformatf("busy_c%0d_we", c), 32'(bus.mem_we), 32'(c <= BUSY_LAST && c != STALL_C));
            if (c == ACK_C) check("busy_rdata", bus.dbg_rdata, 32'hDEAD_BEEF);
        end

        // Reset in the second WAIT cycle: request dropped, no stall, no ack.
        for (int c = 0; c <= 8; c++) begin
            cyc();
            idle_inputs();
            reset          = (c == 2);
            bus.pipe_we    = (c <= 7);
            bus.pipe_addr  = 4'd9;
            bus.pipe_wdata = 32'hA5A5_A5A5;
            bus.dbg_req    = (c < 2);
            bus.dbg_addr   = 4'd5;
            smp();
            check($sformatf("rstw_c%0d_stall", c), 32'(bus.pipe_stall), 32'd0);
            check($sformatf("rstw_c%0d_ack", c), 32'(bus.dbg_ack), 32'd0);
            check($sformatf("rstw_c%0d_we", c), 32'(bus.mem_we), 32'(c <= 7 && c != 2));
        end

        // Reset coinciding with a debug write ACCESS: the write is suppressed.
        pipe_store(4'd11, 32'h1111_1111);
        cyc();
        idle_inputs();
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 4'd11;
        bus.dbg_wdata = 32'hCAFE_F00D;
        smp();
        cyc();
        reset       = 1'b1;
        bus.dbg_req = 1'b0;
        smp();
        check("rsta_we", 32'(bus.mem_we), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            cyc();
            reset = 1'b0;
            smp();
            check($sformatf("rsta_c%0d_stall", c), 32'(bus.pipe_stall), 32'd0);
            check($sformatf("rsta_c%0d_ack", c), 32'(bus.dbg_ack), 32'd0);
        end
        cyc();
        bus.pipe_re   = 1'b1;
        bus.pipe_addr = 4'd11;
        smp();
        cyc();
        idle_inputs();
        smp();
        check("rsta_mem_intact", bus.pipe_rdata, 32'h1111_1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
